// File: rtl/logic_op_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and default width
// for the logic-unit accumulator sequencer.
package logic_op_sequencer_pkg;

    localparam int K_DEF = 4;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_alu(input logic [2:0] op);
        return (op >= OP_NOR) && (op <= OP_NAND);
    endfunction

endpackage

// File: rtl/logic_op_sequencer_settle_counter.sv
// Settle-time down counter: loaded on command accept,
// flags the last cycle the op-unit inputs must be held.
module logic_op_sequencer_settle_counter #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_last
);

    localparam logic [3:0] LOAD_VAL = 4'(SETTLE);

    logic [3:0] r_cnt;

    // Load on accept, count down while executing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_last = (r_cnt == 4'd1);

endmodule

// File: rtl/logic_op_sequencer.sv
// Command-driven accumulator controller that drives the
// external logic op units and returns the new accumulator.
module logic_op_sequencer
    import logic_op_sequencer_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [K-1:0] cmd_data,
    output logic [K-1:0] op_a,
    output logic [K-1:0] op_b,
    output logic [2:0]   op_sel,
    input  logic [K-1:0] op_result,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [K-1:0] resp_data,
    output logic [K-1:0] acc,
    output logic [7:0]   ops_count
);

    state_t       r_state;
    state_t       w_next;
    logic [K-1:0] r_acc;
    logic [K-1:0] r_opb;
    logic [2:0]   r_opq;
    logic [7:0]   r_ops;
    logic [K-1:0] w_acc_next;
    logic         w_accept;
    logic         w_resp_hs;
    logic         w_last;
    logic         w_exec;

    assign w_exec = (r_state == ST_EXEC);

    logic_op_sequencer_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_dec  (w_exec),
        .o_last (w_last)
    );

    // Next state and next accumulator value
    always_comb begin
        w_next     = r_state;
        w_acc_next = r_acc;
        w_accept   = 1'b0;
        w_resp_hs  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (is_alu(cmd_op)) begin
                        w_next = ST_EXEC;
                    end else begin
                        w_next = ST_RESP;
                        if (cmd_op == OP_LOAD) begin
                            w_acc_next = cmd_data;
                        end else if (cmd_op == OP_CLR) begin
                            w_acc_next = '0;
                        end
                    end
                end
            end
            ST_EXEC: begin
                if (w_last) begin
                    w_acc_next = op_result;
                    w_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_resp_hs = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Accumulator, latched command and response counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_opb <= '0;
            r_opq <= OP_NOP;
            r_ops <= 8'd0;
        end else begin
            r_acc <= w_acc_next;
            if (w_accept) begin
                r_opq <= cmd_op;
                r_opb <= cmd_data;
            end
            if (w_resp_hs) begin
                r_ops <= r_ops + 8'd1;
            end
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_acc;
    assign acc        = r_acc;
    assign op_a       = r_acc;
    assign op_b       = r_opb;
    assign op_sel     = w_exec ? r_opq : OP_NOP;
    assign ops_count  = r_ops;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Randomized and directed bench for logic_op_sequencer,
// two instances: SETTLE=1 (index 0) and SETTLE=3 (index 1).
module tb_logic_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n      [2];
    logic       cmd_valid  [2];
    logic       cmd_ready  [2];
    logic [2:0] cmd_op     [2];
    logic [3:0] cmd_data   [2];
    logic [3:0] op_a       [2];
    logic [3:0] op_b       [2];
    logic [2:0] op_sel     [2];
    logic [3:0] op_result  [2];
    logic       resp_valid [2];
    logic       resp_ready [2];
    logic [3:0] resp_data  [2];
    logic [3:0] acc        [2];
    logic [7:0] ops_count  [2];

    logic [3:0] acc_m [2];
    int         cnt_m [2];
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    logic_op_sequencer #(.K(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]),
        .op_a(op_a[0]), .op_b(op_b[0]), .op_sel(op_sel[0]),
        .op_result(op_result[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .acc(acc[0]),
        .ops_count(ops_count[0])
    );

    logic_op_sequencer #(.K(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]),
        .op_a(op_a[1]), .op_b(op_b[1]), .op_sel(op_sel[1]),
        .op_result(op_result[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .acc(acc[1]),
        .ops_count(ops_count[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_alu(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        case (op)
            3'd2:    return ~(a | b);
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return ~(a & b);
            default: return a;
        endcase
    endfunction

    task automatic do_reset(input int d);
        rst_n[d]      = 1'b0;
        cmd_valid[d]  = 1'b0;
        resp_ready[d] = 1'b0;
        @(posedge clk); #1;
        rst_n[d] = 1'b1;
        acc_m[d] = 4'd0;
        cnt_m[d] = 0;
        chk("rst_acc", acc[d], 0);
        chk("rst_rv", resp_valid[d], 0);
        chk("rst_rdy", cmd_ready[d], 1);
        chk("rst_cnt", ops_count[d], 0);
        chk("rst_sel", op_sel[d], 0);
        chk("rst_opb", op_b[d], 0);
    endtask

    // Issue one command from IDLE, run it through response handshake.
    task automatic do_cmd(input int d, input logic [2:0] op,
                          input logic [3:0] data, input int hold,
                          input bit offer, input int want);
        logic [3:0] expv;
        int s;
        s = (d == 0) ? 1 : 3;
        chk("idle_rdy", cmd_ready[d], 1);
        chk("idle_rv", resp_valid[d], 0);
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        cmd_data[d]  = data;
        op_result[d] = 4'($urandom);
        @(posedge clk); #1;
        cmd_valid[d] = 1'b0;
        if (op >= 3'd2 && op <= 3'd6) begin
            expv = ref_alu(op, acc_m[d], data);
            for (int c = 0; c < s; c++) begin
                chk("exec_sel", op_sel[d], op);
                chk("exec_a", op_a[d], acc_m[d]);
                chk("exec_b", op_b[d], data);
                chk("exec_rdy", cmd_ready[d], 0);
                chk("exec_rv", resp_valid[d], 0);
                op_result[d] = (c == s - 1) ? expv :
                    expv ^ 4'($urandom_range(1, 15));
                @(posedge clk); #1;
            end
            acc_m[d] = expv;
        end else if (op == 3'd1) begin
            acc_m[d] = data;
        end else if (op == 3'd7) begin
            acc_m[d] = 4'd0;
        end
        op_result[d] = 4'($urandom);
        chk("resp_rv", resp_valid[d], 1);
        chk("resp_data", resp_data[d], acc_m[d]);
        chk("resp_sel", op_sel[d], 0);
        chk("resp_rdy", cmd_ready[d], 0);
        chk("resp_acc", acc[d], acc_m[d]);
        if (want >= 0) chk("directed", resp_data[d], want);
        for (int h = 0; h < hold; h++) begin
            if (offer) begin
                cmd_valid[d] = 1'b1;
                cmd_op[d]    = 3'd1;
                cmd_data[d]  = 4'd1;
            end
            @(posedge clk); #1;
            chk("hold_rv", resp_valid[d], 1);
            chk("hold_rdy", cmd_ready[d], 0);
            chk("hold_data", resp_data[d], acc_m[d]);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        cnt_m[d] = (cnt_m[d] + 1) % 256;
        chk("post_rv", resp_valid[d], 0);
        chk("post_rdy", cmd_ready[d], 1);
        chk("post_cnt", ops_count[d], cnt_m[d]);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d]      = 1'b0;
            cmd_valid[d]  = 1'b0;
            cmd_op[d]     = 3'd0;
            cmd_data[d]   = 4'd0;
            op_result[d]  = 4'd0;
            resp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset(0);
        do_reset(1);

        do_cmd(0, 3'd1, 4'b1111, 0, 0, 15);
        do_cmd(0, 3'd2, 4'b1010, 0, 0, 0);
        chk("cnt_two", ops_count[0], 2);

        do_cmd(0, 3'd1, 4'b1100, 0, 0, 12);
        do_cmd(0, 3'd5, 4'b1010, 0, 0, 6);
        do_cmd(0, 3'd3, 4'b0110, 0, 0, 6);
        do_cmd(0, 3'd6, 4'b1111, 0, 0, 9);

        do_cmd(1, 3'd1, 4'b0101, 0, 0, 5);
        do_cmd(1, 3'd2, 4'b0000, 0, 0, 10);

        do_cmd(1, 3'd1, 4'b0011, 10, 1, 3);
        do_cmd(1, 3'd1, 4'b0001, 0, 0, 1);

        cmd_valid[1] = 1'b1;
        cmd_op[1]    = 3'd4;
        cmd_data[1]  = 4'b1000;
        @(posedge clk); #1;
        cmd_valid[1] = 1'b0;
        chk("mid_exec", op_sel[1], 4);
        do_reset(1);

        do_cmd(1, 3'd1, 4'b0110, 0, 0, 6);
        cmd_valid[1] = 1'b1;
        cmd_op[1]    = 3'd1;
        cmd_data[1]  = 4'b1110;
        @(posedge clk); #1;
        cmd_valid[1] = 1'b0;
        chk("mid_resp", resp_valid[1], 1);
        do_reset(1);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                do_cmd(d, 3'($urandom_range(0, 7)),
                       4'($urandom), $urandom_range(0, 2), 0, -1);
            end
        end

        do_reset(0);
        do_cmd(0, 3'd1, 4'b1001, 0, 0, 9);
        for (int i = 0; i < 256; i++) begin
            do_cmd(0, 3'd0, 4'($urandom), 0, 0, 9);
            if (i == 254) chk("wrap", ops_count[0], 0);
        end
        chk("nop_acc", acc[0], 9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
